// File: rtl/cpu_param.sv
// +----------------------------------------------------------------------------
// | cpu_param : parametrised A-RISC core (16-bit instructions, W-bit datapath)
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module cpu_param #(
  parameter int W       = 8,
  parameter int NUM_GPR = 8,
  parameter int IADDR_W = 8,
  parameter int DADDR_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  output logic [IADDR_W-1:0] iram_addr,
  input  logic [15:0]        iram_dout,
  output logic               dram_req,
  output logic               dram_write,
  output logic [DADDR_W-1:0] dram_addr,
  output logic [W-1:0]       dram_din,
  input  logic [W-1:0]       dram_dout,
  input  logic               dram_ack,
  output logic               idle,
  output logic               error,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  localparam logic [3:0] OP_END = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_MUL = 4'd3;
  localparam logic [3:0] OP_DV2 = 4'd4;
  localparam logic [3:0] OP_LDC = 4'd5;
  localparam logic [3:0] OP_LDM = 4'd6;
  localparam logic [3:0] OP_STM = 4'd7;
  localparam logic [3:0] OP_MOV = 4'd8;
  localparam logic [3:0] OP_BNE = 4'd9;
  localparam logic [3:0] OP_BLT = 4'd10;

  state_t             state_q;
  logic [IADDR_W-1:0] pc_q;
  logic [W-1:0]       adr_q;
  logic [W-1:0]       jad_q;
  logic [W-1:0]       din_q;
  logic [W-1:0]       gpr_q [NUM_GPR];
  logic [CNT_W-1:0]   cnt_q;
  logic               err_q;
  logic               req_q;
  logic               wr_q;
  logic [DADDR_W-1:0] daddr_q;
  logic [W-1:0]       ddin_q;

  logic [3:0]         opc, rd, ra, rb;
  logic [W-1:0]       con;
  logic [W-1:0]       ra_val, rb_val;
  logic [W-1:0]       alu_res;
  logic [W-1:0]       half;
  logic               wr_en, taken, mem_op, illegal;
  logic [IADDR_W-1:0] jad_pc, pc_d;
  logic [DADDR_W-1:0] adr_dram;
  logic [CNT_W-1:0]   cnt_d;

  assign opc = iram_dout[3:0];
  assign rd  = iram_dout[7:4];
  assign ra  = iram_dout[11:8];
  assign rb  = iram_dout[15:12];

  if (IADDR_W <= W) begin : g_jad_trunc
    assign jad_pc = jad_q[IADDR_W-1:0];
  end else begin : g_jad_ext
    assign jad_pc = {{(IADDR_W-W){1'b0}}, jad_q};
  end

  if (DADDR_W <= W) begin : g_adr_trunc
    assign adr_dram = adr_q[DADDR_W-1:0];
  end else begin : g_adr_ext
    assign adr_dram = {{(DADDR_W-W){1'b0}}, adr_q};
  end

  always_comb begin
    con      = '0;
    con[7:0] = {ra, rb};
  end

  function automatic logic [W-1:0] reg_read(input logic [3:0] idx);
    logic [W-1:0] v;
    v = '0;
    case (idx)
      4'd0: v = '0;
      4'd1: v = W'(1);
      4'd2: v = din_q;
      4'd3: v = con;
      4'd4: v = adr_q;
      4'd5: v = jad_q;
      default: begin
        for (int g = 0; g < NUM_GPR; g++) begin
          if (idx == 4'(g + 6)) v = gpr_q[g];
        end
      end
    endcase
    return v;
  endfunction

  assign ra_val = reg_read(ra);
  assign rb_val = reg_read(rb);

  // Bias negatives by one before the arithmetic shift so the result truncates toward zero.
  assign half = ra_val + W'(ra_val[W-1]);

  always_comb begin
    alu_res = '0;
    wr_en   = 1'b0;
    taken   = 1'b0;
    mem_op  = 1'b0;
    illegal = 1'b0;
    case (opc)
      OP_END: ;
      OP_ADD: begin alu_res = ra_val + rb_val; wr_en = 1'b1; end
      OP_SUB: begin alu_res = ra_val - rb_val; wr_en = 1'b1; end
      OP_MUL: begin alu_res = ra_val * rb_val; wr_en = 1'b1; end
      OP_DV2: begin alu_res = {half[W-1], half[W-1:1]}; wr_en = 1'b1; end
      OP_LDC: begin alu_res = con; wr_en = 1'b1; end
      OP_LDM, OP_STM: mem_op = 1'b1;
      OP_MOV: begin alu_res = ra_val; wr_en = 1'b1; end
      OP_BNE: taken = (ra_val != rb_val);
      OP_BLT: taken = ($signed(ra_val) < $signed(rb_val));
      default: illegal = 1'b1;
    endcase
  end

  assign pc_d  = (opc == OP_END) ? '0 : (taken ? jad_pc : pc_q + 1'b1);
  assign cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      adr_q   <= '0;
      jad_q   <= '0;
      din_q   <= '0;
      for (int g = 0; g < NUM_GPR; g++) gpr_q[g] <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      daddr_q <= '0;
      ddin_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_ERROR: begin
          if (start) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
          end
        end
        S_FETCH: state_q <= S_EXEC;
        S_EXEC: begin
          if (illegal) begin
            state_q <= S_ERROR;
            err_q   <= 1'b1;
          end else if (mem_op) begin
            state_q <= S_MEM;
            req_q   <= 1'b1;
            wr_q    <= (opc == OP_STM);
            daddr_q <= adr_dram;
            if (opc == OP_STM) ddin_q <= ra_val;
          end else begin
            if (wr_en) begin
              case (rd)
                4'd4: adr_q <= alu_res;
                4'd5: jad_q <= alu_res;
                default: begin
                  for (int g = 0; g < NUM_GPR; g++) begin
                    if (rd == 4'(g + 6)) gpr_q[g] <= alu_res;
                  end
                end
              endcase
            end
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            state_q <= (opc == OP_END) ? S_IDLE : S_FETCH;
          end
        end
        S_MEM: begin
          if (dram_ack) begin
            req_q   <= 1'b0;
            wr_q    <= 1'b0;
            if (!wr_q) din_q <= dram_dout;
            pc_q    <= pc_q + 1'b1;
            cnt_q   <= cnt_d;
            state_q <= S_FETCH;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign iram_addr   = pc_q;
  assign dram_req    = req_q;
  assign dram_write  = wr_q;
  assign dram_addr   = daddr_q;
  assign dram_din    = ddin_q;
  assign idle        = (state_q == S_IDLE);
  assign error       = err_q;
  assign instr_count = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_param.sv
// +----------------------------------------------------------------------------
// | tb_cpu_param : directed self-checking bench for cpu_param (W=8 and W=16)
// | Rev 1.0
// +----------------------------------------------------------------------------
`default_nettype none

module tb_cpu_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] rd,
                                      input logic [3:0] ra, input logic [3:0] rb);
    return {rb, ra, rd, op};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- W=8 instance and its memories ----------------
  logic        rstn8, start8, req8, wr8, ack8, idle8, err8;
  logic [7:0]  ia8, da8, dd8, dq8;
  logic [15:0] id8, cnt8;
  logic [15:0] imem8 [256];
  logic [7:0]  dmem8 [256];
  logic [15:0] wlog8 [$];
  int          delay8 = 0;
  int          wcnt8 = 0;

  cpu_param #(.W(8), .NUM_GPR(8), .IADDR_W(8), .DADDR_W(8), .CNT_W(16)) dut8 (
    .clk(clk), .rstn(rstn8), .start(start8),
    .iram_addr(ia8), .iram_dout(id8),
    .dram_req(req8), .dram_write(wr8), .dram_addr(da8), .dram_din(dd8),
    .dram_dout(dq8), .dram_ack(ack8),
    .idle(idle8), .error(err8), .instr_count(cnt8)
  );

  always @(posedge clk) id8 <= imem8[ia8];
  assign ack8 = req8 && (wcnt8 == delay8);
  assign dq8  = ack8 ? dmem8[da8] : 8'hEE;
  always @(posedge clk) begin
    if (req8 && !ack8) wcnt8 <= wcnt8 + 1;
    else               wcnt8 <= 0;
    if (req8 && ack8 && wr8) wlog8.push_back({da8, dd8});
  end

  // ---------------- W=16 instance and its memories ----------------
  logic        rstn16, start16, req16, wr16, ack16, idle16, err16;
  logic [7:0]  ia16, da16;
  logic [15:0] id16, dd16, dq16, cnt16;
  logic [15:0] imem16 [256];
  logic [23:0] wlog16 [$];

  cpu_param #(.W(16), .NUM_GPR(8), .IADDR_W(8), .DADDR_W(8), .CNT_W(16)) dut16 (
    .clk(clk), .rstn(rstn16), .start(start16),
    .iram_addr(ia16), .iram_dout(id16),
    .dram_req(req16), .dram_write(wr16), .dram_addr(da16), .dram_din(dd16),
    .dram_dout(dq16), .dram_ack(ack16),
    .idle(idle16), .error(err16), .instr_count(cnt16)
  );

  always @(posedge clk) id16 <= imem16[ia16];
  assign ack16 = req16;
  assign dq16  = 16'h0000;
  always @(posedge clk) if (req16 && ack16 && wr16) wlog16.push_back({da16, dd16});

  // ---------------- helpers ----------------
  task automatic clear_imem8();
    for (int i = 0; i < 256; i++) imem8[i] = 16'h0000;
  endtask

  task automatic start_run8();
    @(negedge clk);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
  endtask

  task automatic wait_done8(input int budget, output int cycles);
    cycles = 0;
    while (!(idle8 || err8) && cycles < budget) begin
      tick();
      cycles++;
    end
    check_eq("done8_within_budget", 32'(idle8 || err8), 32'd1);
  endtask

  int          cyc, nreq, nwr;
  logic        addr_bad, wrapped;
  logic [7:0]  post_addr, prev;
  logic        post_req;

  initial begin
    rstn8 = 1'b0; rstn16 = 1'b0; start8 = 1'b0; start16 = 1'b0;
    clear_imem8();
    for (int i = 0; i < 256; i++) begin
      imem16[i] = 16'h0000;
      dmem8[i]  = 8'(i * 3);
    end
    dmem8[8'h21] = 8'hA5;
    repeat (2) @(negedge clk);

    // Reset values while reset is asserted
    check_eq("rst_idle", 32'(idle8), 32'd1);
    check_eq("rst_req", 32'(req8), 32'd0);
    check_eq("rst_count", 32'(cnt8), 32'd0);
    check_eq("rst_pc", 32'(ia8), 32'd0);
    check_eq("rst_error", 32'(err8), 32'd0);
    check_eq("rst_dram_addr", 32'(da8), 32'd0);
    rstn8 = 1'b1; rstn16 = 1'b1;
    tick();

    // Test 1: LDC/LDC/ADD/MOV/STM/END
    imem8[0] = ins(4'd5, 4'd6, 4'd0, 4'd5);
    imem8[1] = ins(4'd5, 4'd7, 4'd0, 4'd3);
    imem8[2] = ins(4'd1, 4'd8, 4'd6, 4'd7);
    imem8[3] = ins(4'd8, 4'd4, 4'd8, 4'd0);
    imem8[4] = ins(4'd7, 4'd0, 4'd8, 4'd0);
    imem8[5] = ins(4'd0, 4'd0, 4'd0, 4'd0);
    nwr = wlog8.size();
    start_run8();
    check_eq("t1_started", 32'(idle8), 32'd0);
    repeat (6) tick();
    check_eq("t1_pc_after_3_alu", 32'(ia8), 32'd3);
    wait_done8(50, cyc);
    check_eq("t1_remaining_cycles", 32'(cyc), 32'd7);
    check_eq("t1_count", 32'(cnt8), 32'd6);
    check_eq("t1_nwrites", 32'(wlog8.size() - nwr), 32'd1);
    check_eq("t1_write", 32'(wlog8[wlog8.size()-1]), 32'h0808);
    check_eq("t1_pc_after_end", 32'(ia8), 32'd0);

    // Test 2: LDM with ack delayed 3 cycles
    clear_imem8();
    imem8[0] = ins(4'd5, 4'd4, 4'd2, 4'd1);
    imem8[1] = ins(4'd6, 4'd0, 4'd0, 4'd0);
    imem8[2] = ins(4'd8, 4'd6, 4'd2, 4'd0);
    imem8[3] = ins(4'd7, 4'd0, 4'd6, 4'd0);
    delay8 = 3;
    nwr = wlog8.size();
    start_run8();
    repeat (3) tick();
    nreq = 0; addr_bad = 1'b0; post_addr = 8'h00; post_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (req8) begin
        nreq++;
        if (da8 != 8'h21 || wr8) addr_bad = 1'b1;
      end
      if (k == 4) begin
        post_addr = ia8;
        post_req  = req8;
      end
    end
    check_eq("t2_req_cycles", 32'(nreq), 32'd4);
    check_eq("t2_addr_stable", 32'(addr_bad), 32'd0);
    check_eq("t2_next_fetch_pc", 32'(post_addr), 32'd2);
    check_eq("t2_req_dropped", 32'(post_req), 32'd0);
    wait_done8(80, cyc);
    check_eq("t2_count", 32'(cnt8), 32'd5);
    check_eq("t2_din_stored", 32'(wlog8[wlog8.size()-1]), 32'h21A5);
    delay8 = 0;

    // Test 3: signed BLT under overflow, BNE
    clear_imem8();
    imem8[0]     = ins(4'd5, 4'd6, 4'd6, 4'd4);
    imem8[1]     = ins(4'd5, 4'd7, 4'd9, 4'd12);
    imem8[2]     = ins(4'd5, 4'd5, 4'd2, 4'd0);
    imem8[3]     = ins(4'd10, 4'd0, 4'd6, 4'd7);
    imem8[4]     = ins(4'd10, 4'd0, 4'd7, 4'd6);
    imem8[5]     = ins(4'd12, 4'd0, 4'd0, 4'd0);
    imem8[8'h20] = ins(4'd9, 4'd0, 4'd6, 4'd6);
    imem8[8'h21] = ins(4'd0, 4'd0, 4'd0, 4'd0);
    start_run8();
    repeat (8) tick();
    check_eq("t3_blt_not_taken", 32'(ia8), 32'd4);
    repeat (2) tick();
    check_eq("t3_blt_taken", 32'(ia8), 32'h20);
    wait_done8(50, cyc);
    check_eq("t3_no_error", 32'(err8), 32'd0);
    check_eq("t3_count", 32'(cnt8), 32'd7);

    // Test 4: illegal opcode trap and restart
    clear_imem8();
    imem8[0] = ins(4'd5, 4'd6, 4'd1, 4'd1);
    imem8[1] = ins(4'd5, 4'd7, 4'd2, 4'd2);
    imem8[2] = ins(4'd8, 4'd4, 4'd6, 4'd0);
    imem8[3] = ins(4'd12, 4'd6, 4'd7, 4'd0);
    start_run8();
    wait_done8(50, cyc);
    check_eq("t4_error", 32'(err8), 32'd1);
    check_eq("t4_not_idle", 32'(idle8), 32'd0);
    check_eq("t4_count", 32'(cnt8), 32'd3);
    check_eq("t4_pc_held", 32'(ia8), 32'd3);
    repeat (3) tick();
    check_eq("t4_error_held", 32'(err8), 32'd1);
    clear_imem8();
    imem8[0] = ins(4'd7, 4'd0, 4'd6, 4'd0);
    nwr = wlog8.size();
    start_run8();
    check_eq("t4_error_cleared", 32'(err8), 32'd0);
    check_eq("t4_restart_pc", 32'(ia8), 32'd0);
    check_eq("t4_restart_count", 32'(cnt8), 32'd0);
    wait_done8(50, cyc);
    check_eq("t4_r6_unchanged", 32'(wlog8[wlog8.size()-1]), 32'h1111);
    check_eq("t4_nwrites", 32'(wlog8.size() - nwr), 32'd1);

    // Test 5: async reset while waiting for ack
    clear_imem8();
    imem8[0] = ins(4'd5, 4'd4, 4'd3, 4'd0);
    imem8[1] = ins(4'd6, 4'd0, 4'd0, 4'd0);
    delay8 = 1000;
    start_run8();
    cyc = 0;
    while (!req8 && cyc < 20) begin
      tick();
      cyc++;
    end
    check_eq("t5_req_seen", 32'(req8), 32'd1);
    repeat (2) tick();
    #2 rstn8 = 1'b0;
    #1;
    check_eq("t5_req_async_drop", 32'(req8), 32'd0);
    check_eq("t5_idle", 32'(idle8), 32'd1);
    check_eq("t5_dram_addr", 32'(da8), 32'd0);
    check_eq("t5_pc", 32'(ia8), 32'd0);
    @(negedge clk);
    rstn8 = 1'b1;
    delay8 = 0;
    tick();
    check_eq("t5_idle_after_release", 32'(idle8), 32'd1);
    clear_imem8();
    imem8[0] = ins(4'd7, 4'd0, 4'd6, 4'd0);
    nwr = wlog8.size();
    start_run8();
    wait_done8(50, cyc);
    check_eq("t5_nwrites", 32'(wlog8.size() - nwr), 32'd1);
    check_eq("t5_regs_zero", 32'(wlog8[wlog8.size()-1]), 32'h0000);

    // Test 6: W=16 MUL/DV2/SUB and pc wrap 255 -> 0
    imem16[0]     = ins(4'd9, 4'd0, 4'd10, 4'd0);
    imem16[1]     = ins(4'd5, 4'd6, 4'd9, 4'd6);
    imem16[2]     = ins(4'd1, 4'd6, 4'd6, 4'd6);
    imem16[3]     = ins(4'd3, 4'd7, 4'd6, 4'd6);
    imem16[4]     = ins(4'd5, 4'd8, 4'd0, 4'd7);
    imem16[5]     = ins(4'd2, 4'd8, 4'd0, 4'd8);
    imem16[6]     = ins(4'd4, 4'd9, 4'd8, 4'd0);
    imem16[7]     = ins(4'd5, 4'd4, 4'd4, 4'd0);
    imem16[8]     = ins(4'd7, 4'd0, 4'd7, 4'd0);
    imem16[9]     = ins(4'd5, 4'd4, 4'd4, 4'd1);
    imem16[10]    = ins(4'd7, 4'd0, 4'd9, 4'd0);
    imem16[11]    = ins(4'd5, 4'd5, 4'd15, 4'd14);
    imem16[12]    = ins(4'd9, 4'd0, 4'd0, 4'd1);
    imem16[8'hFE] = ins(4'd5, 4'd5, 4'd15, 4'd0);
    imem16[8'hFF] = ins(4'd5, 4'd10, 4'd0, 4'd1);
    imem16[8'hF0] = ins(4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    start16 = 1'b1;
    tick();
    start16 = 1'b0;
    cyc = 0; wrapped = 1'b0; prev = ia16;
    while (!(idle16 || err16) && cyc < 300) begin
      tick();
      cyc++;
      if (prev == 8'hFF && ia16 == 8'h00) wrapped = 1'b1;
      prev = ia16;
    end
    check_eq("t6_done16", 32'(idle16), 32'd1);
    check_eq("t6_pc_wrap", 32'(wrapped), 32'd1);
    check_eq("t6_count", 32'(cnt16), 32'd17);
    check_eq("t6_nwrites", 32'(wlog16.size()), 32'd2);
    if (wlog16.size() >= 2) begin
      check_eq("t6_mul_300x300", 32'(wlog16[0]), 32'h405F90);
      check_eq("t6_dv2_minus7", 32'(wlog16[1]), 32'h41FFFD);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpu_param.md
Name: cpu_param

Overview:
Parametrised successor to the 8-bit A-RISC core. It keeps the 16-bit instruction format and the opcode set, and makes data width and GPR count configurable. New behaviour over the 8-bit core:
- a ready/ack handshake to DRAM with unbounded wait states
- true signed branch compare (no subtraction-overflow error)
- illegal-opcode trap
- retired-instruction counter

It sits between a synchronous-read instruction RAM and a data memory or interconnect.

Parameters:
W, 8, data/register width in bits (≥8)
NUM_GPR, 8, general-purpose registers (1..10; register file index = 6 + gpr number)
IADDR_W, 8, instruction address width
DADDR_W, 8, data address width (ADR low DADDR_W bits, zero-extended if W<DADDR_W)
CNT_W, 16, width of instr_count

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
start  in  1  begin execution at address 0 (sampled only in IDLE/ERROR)
iram_addr  out  IADDR_W  instruction address (= pc)
iram_dout  in  16  instruction {rb[15:12], ra[11:8], rd[7:4], opcode[3:0]}, valid the cycle after iram_addr is set
dram_req  out  1  memory request, held until ack
dram_write  out  1  1=store, 0=load; valid while dram_req
dram_addr  out  DADDR_W  memory address (ADR)
dram_din  out  W  store data
dram_dout  in  W  load data, valid on the dram_ack cycle
dram_ack  in  1  request complete this cycle
idle  out  1  state==IDLE
error  out  1  illegal-opcode trap
instr_count  out  CNT_W  retired instructions since last start, saturating

Behaviour:
- Reset (async, rstn=0): state=IDLE; pc, ADR, JAD, DIN, GPRs, instr_count = 0; dram_req, dram_write, error = 0; idle=1; dram_addr, dram_din = 0. dram_req must drop in the same instant as the reset, even mid-transaction.
- Register map: 0=const 0, 1=const 1, 2=DIN, 3=CON, 4=ADR, 5=JAD, 6..5+NUM_GPR=GPR.
  - Reads of index ≥6+NUM_GPR return 0.
  - Writes to 0, 1, 2, 3 or to out-of-range indices are ignored.
  - DIN is written only by LDM.
- CON = {ra,rb}, zero-extended to W.
- FSM states: IDLE, FETCH, EXEC, MEM, ERROR.
  - IDLE: on start → FETCH, with pc=0, instr_count=0, error=0.
  - FETCH (1 cycle): iram_addr=pc.
  - EXEC: decode iram_dout and commit at the clock edge.
    - Non-memory opcode → FETCH.
    - LDM/STM → MEM.
    - END → IDLE.
    - Opcodes 11..15 → ERROR (error=1, no register write, pc unchanged).
  - MEM: dram_req=1, with dram_addr/dram_write/dram_din stable.
    - On the dram_ack edge: LDM latches dram_dout into DIN, then → FETCH.
    - With no ack, remain in MEM indefinitely.
  - ERROR: hold until start (→ FETCH as from IDLE).
  - start is ignored in FETCH, EXEC and MEM.
- iram_addr holds pc through FETCH/EXEC/MEM, so synchronous RAM output stays valid.
- Latency: ALU/LDC/MOV/branch take 2 cycles; LDM/STM take 3+N cycles (N = cycles before ack).
- Opcodes and semantics:
  - 0 END: pc←0.
  - 1 ADD: R[rd]←R[ra]+R[rb].
  - 2 SUB: R[rd]←R[ra]−R[rb].
  - 3 MUL: R[rd]←low W bits of R[ra]·R[rb].
  - 4 DV2: R[rd]←R[ra]/2, signed, truncating toward zero (−3→−1).
  - 5 LDC: R[rd]←CON.
  - 6 LDM: DIN←DRAM[ADR].
  - 7 STM: DRAM[ADR]←R[ra].
  - 8 MOV: R[rd]←R[ra].
  - 9 BNE: taken if R[ra]≠R[rb].
  - 10 BLT: taken if R[ra]<R[rb], full signed compare, correct under overflow.
- Arithmetic: two's complement, wraps modulo 2^W.
- pc update at commit: branch taken → pc←JAD (low IADDR_W bits); otherwise pc←pc+1, wrapping at 2^IADDR_W−1→0. There is no branch delay slot.
- Writes and pc update occur on the same edge as the commit; a GPR read in the next instruction sees the new value.
- instr_count increments once per committed instruction (END included, illegal excluded) and saturates at all-ones.

Test Plan:
- W=8: LDC r6←5, LDC r7←3, ADD r8←r6+r7, STM (ADR=r8 via MOV r4←r8), END → one write of 8 to DRAM[8]; instr_count=6; idle returns; ALU instructions take 2 cycles each.
- LDM with dram_ack delayed 3 cycles → dram_req high 4 consecutive cycles, with addr stable throughout; DIN = dram_dout from the ack cycle; the next FETCH follows immediately.
- W=8, r6=100, r7=−100, BLT r6,r7 with JAD=0x20 → not taken (pc+1); swapped operands → taken, next iram_addr=0x20.
- Opcode 12 at address 3 → error=1, state ERROR, no register change, instr_count=3; start → error=0, fetch from 0.
- rstn low while dram_req=1 awaiting ack → dram_req=0 immediately; after release idle=1, all registers 0, and start runs from address 0.
- W=16: MUL 300·300 → 0x5F90 (90000 mod 65536); DV2 on −7 → −3; pc wrap from 255 to 0 with IADDR_W=8.
